// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage with word-organised instruction memory, delay-slot
// redirects (jump > branch > pending > PC+4), stall/flush control, a one-entry
// pending redirect captured while stalled, and a sticky misaligned-target flag.
//
// Handshake: there is no valid/ready pair on this block. A new fetch is
// accepted on every rising edge where stall=0; valid_out qualifies
// instr_out/pc_out/pc_plus4_out and stays stable while stall=1 (flush may
// still drop it).
module instruction_fetch_unit #(
    parameter int                 ADDR_W    = 32,
    parameter int                 MEM_BYTES = 4096,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [31:0]       imem_wdata,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4_out,
    output logic              valid_out,
    output logic              align_fault
);

    localparam int WORDS = MEM_BYTES / 4;
    localparam int IDX_W = $clog2(MEM_BYTES);

    // Memory holds whole words. Because the PC is always word-aligned, the
    // four fetched bytes PC..PC+3 are exactly one stored word, and storing
    // the big-endian write word unchanged gives the big-endian read back.
    logic [31:0] mem_q [WORDS];

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [ADDR_W-1:0] pc4_out_q, pc4_out_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;

    logic              redir_valid;
    logic [ADDR_W-1:0] redir_raw;
    logic [ADDR_W-1:0] redir_target;
    logic              redir_misaligned;
    logic [ADDR_W-1:0] pc_plus4;
    logic [IDX_W-3:0]  fetch_idx;
    logic [IDX_W-3:0]  write_idx;
    logic [31:0]       fetch_word;

    // Address bits that never select a word (sub-word and above the memory).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_waddr[1:0], imem_waddr[ADDR_W-1:IDX_W],
                                pc_q[1:0], pc_q[ADDR_W-1:IDX_W]};

    // Jump wins over branch; the winning target is forced word-aligned.
    assign redir_valid      = jump | branch_taken;
    assign redir_raw        = jump ? jump_target : branch_target;
    assign redir_target     = {redir_raw[ADDR_W-1:2], 2'b00};
    assign redir_misaligned = redir_valid && (redir_raw[1:0] != 2'b00);

    assign pc_plus4   = pc_q + ADDR_W'(4);
    assign fetch_idx  = pc_q[IDX_W-1:2];
    assign write_idx  = imem_waddr[IDX_W-1:2];
    assign fetch_word = mem_q[fetch_idx];

    // Next-state selection for the PC, output registers and pending redirect.
    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        pc4_out_d     = pc4_out_q;
        valid_d       = valid_q;
        fault_d       = fault_q | redir_misaligned;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (stall) begin
            if (flush) begin
                valid_d = 1'b0;
            end
            if (redir_valid) begin
                pend_valid_d  = 1'b1;
                pend_target_d = redir_target;
            end
        end else begin
            instr_d      = fetch_word;
            pc_out_d     = pc_q;
            pc4_out_d    = pc_plus4;
            valid_d      = !flush;
            pend_valid_d = 1'b0;
            if (redir_valid) begin
                pc_d = redir_target;
            end else if (pend_valid_q) begin
                pc_d = pend_target_q;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    // Fetch-stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            pc_out_q      <= '0;
            pc4_out_q     <= '0;
            valid_q       <= 1'b0;
            fault_q       <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            pc4_out_q     <= pc4_out_d;
            valid_q       <= valid_d;
            fault_q       <= fault_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Program load port; not gated by reset, and a same-cycle fetch sees old data.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem_q[write_idx] <= imem_wdata;
        end
    end

    assign instr_out    = instr_q;
    assign pc_out       = pc_out_q;
    assign pc_plus4_out = pc4_out_q;
    assign valid_out    = valid_q;
    assign align_fault  = fault_q;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address and PC width.
REQ-002 Parameter MEM_BYTES, default 4096: instruction memory size in bytes; power of two, multiple of 4.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: PC value after reset; word-aligned.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 stall  in  1: hold the fetch stage (PC and outputs frozen).
REQ-007 flush  in  1: squash the instruction that would be presented next cycle.
REQ-008 jump  in  1: unconditional redirect request.
REQ-009 jump_target  in  ADDR_W: jump destination.
REQ-010 branch_taken  in  1: taken-branch redirect request.
REQ-011 branch_target  in  ADDR_W: branch destination.
REQ-012 imem_we  in  1: instruction memory word write enable (program load).
REQ-013 imem_waddr  in  ADDR_W: write byte address; bits [1:0] ignored.
REQ-014 imem_wdata  in  32: write word, big-endian (bits [31:24] to lowest byte).
REQ-015 instr_out  out  32: fetched instruction, big-endian assembly of 4 bytes.
REQ-016 pc_out  out  ADDR_W: address of instr_out.
REQ-017 pc_plus4_out  out  ADDR_W: pc_out + 4, modulo 2^ADDR_W.
REQ-018 valid_out  out  1: instr_out/pc_out hold a live instruction.
REQ-019 align_fault  out  1: sticky flag, a misaligned redirect target was seen.

Function
REQ-020 Internal PC register; memory index = PC modulo MEM_BYTES (address wrap, no fault).
REQ-021 Cycle with stall=0: instr_out <= mem[PC..PC+3], pc_out <= PC, pc_plus4_out <= PC+4, valid_out <= !flush; fetch latency one cycle.
REQ-022 Next-PC priority when stall=0: jump > branch_taken > pending redirect > PC+4.
REQ-023 A redirect asserted in cycle N affects the PC used from cycle N+1; the word fetched in cycle N is still delivered (MIPS delay slot).
REQ-024 Cycle with stall=1: PC, instr_out, pc_out, pc_plus4_out, valid_out hold; flush during stall clears valid_out only.
REQ-025 Redirect during stall is stored in a one-entry pending register (target only); a later redirect during the same stall overwrites it (jump still beats branch in one cycle).
REQ-026 Pending redirect is consumed on the first cycle with stall=0 and cleared; a live jump/branch in that cycle overrides and clears it.
REQ-027 Redirect target with bits [1:0] != 0: PC loads target with bits [1:0] forced to 0 and align_fault sets to 1 until reset.
REQ-028 Memory write: word at imem_waddr updated at the edge; a fetch of the same word in the same cycle returns the old data.
REQ-029 PC+4 wraps modulo 2^ADDR_W with no flag.
REQ-030 All arithmetic unsigned, ADDR_W bits; fetch byte addresses PC..PC+3 wrap modulo MEM_BYTES.

Reset
REQ-031 reset=1 at an edge: PC <= RESET_PC, instr_out <= 0, pc_out <= 0, pc_plus4_out <= 0, valid_out <= 0, align_fault <= 0, pending redirect cleared.
REQ-032 reset dominates stall, flush, jump, branch_taken; memory contents are not reset; imem writes still occur during reset.
REQ-033 First fetch after release is from RESET_PC; valid_out rises one cycle after reset drops.

Verification
REQ-034 Load words 0x11223344 at 0x0, 0xAABBCCDD at 0x4; release reset -> instr_out 0x11223344/pc_out 0x0, then 0xAABBCCDD/pc_out 0x4, valid_out 1.
REQ-035 branch_taken=1, branch_target=0x40 in cycle fetching 0x8 -> next outputs pc_out 0x8 (delay slot), then 0x40.
REQ-036 stall=1 for 3 cycles with jump to 0x100 in 2nd stall cycle, then stall=0 -> outputs frozen for 3 cycles, next fetch pc_out 0x100.
REQ-037 jump and branch_taken together, targets 0x200/0x300 -> PC 0x200; jump_target 0x202 -> PC 0x200, align_fault 1 and remains 1.
REQ-038 MEM_BYTES=4096, PC=0xFFC then 0x1000 -> second fetch reads memory word 0x000, pc_out 0x1000.
REQ-039 reset asserted mid-stream with pending redirect -> next cycle valid_out 0, align_fault 0; after release first pc_out = RESET_PC.
